// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the pipeline-stage buffers.
//   - Bundle widths for each stage boundary.
//   - clog2(): pointer and occupancy sizing, usable in parameter expressions.
//   - aluControl_t: the 14-bit ALUControl field carried inside the D/E bundle.
//   - occState_t: names for the buffer occupancy states (EMPTY/PARTIAL/FULL).
package pipe_pkg;

    localparam int DE_BUNDLE_W = 120;  // PC+2, control, operands, Inst, register IDs
    localparam int FD_BUNDLE_W = 33;

    typedef logic [13:0] aluControl_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occState_t;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(8) = 3.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: stage-boundary bus for pipe_stage_buf.
//   Upstream side : in_valid, in_ready, in_data, flush
//   Downstream side: out_valid, out_ready, out_data
//   Status        : count (occupancy)
// Modports: slave = the buffer, master = the surrounding stages.
//
// Handshake: a transfer happens at a rising clk edge exactly when valid and
// ready are both 1 on that side. valid may rise or drop at any time without
// waiting for ready; data is only meaningful while valid is 1 and is sampled
// only on the transferring edge. in_ready may depend combinationally on
// out_ready (full buffer still accepts when the head is leaving).
interface pipe_stage_buf_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = DE_BUNDLE_W,
    parameter int DEPTH  = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [clog2(DEPTH):0]    count;

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, count
    );

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_buf_ptr.sv
// pipe_buf_ptr: wrap-around read/write pointers plus occupancy counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, pop  : advance wrPtr / rdPtr (caller guarantees no overflow/underflow)
//   clear      : synchronous return to empty; overrides push and pop
//   wrPtr      : next slot to write
//   rdPtr      : head slot
//   count      : occupancy, 0..DEPTH
// DEPTH is a power of two, so the pointers wrap by natural overflow.
module pipe_buf_ptr
    import pipe_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    output logic [PTR_W-1:0] wrPtr,
    output logic [PTR_W-1:0] rdPtr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            // Simultaneous push and pop leaves occupancy unchanged.
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline register with a DEPTH-entry skid FIFO.
//   clk, rst_n   : stage clock, asynchronous active-low reset
//   bus (slave)  : in_valid/in_ready/in_data, flush,
//                  out_valid/out_ready/out_data, count
//   perf_clr     : (PIPE_STAGE_PERF_EN) synchronous clear of stall_cycles
//   stall_cycles : (PIPE_STAGE_PERF_EN) saturating count of cycles with
//                  out_valid & ~out_ready
// Optional feature macro: PIPE_STAGE_PERF_EN (undefined by default).
// DATA_W and DEPTH must match the parameters of the connected interface.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W      = DE_BUNDLE_W,
    parameter int DEPTH       = 2,
    parameter bit ZERO_BUBBLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef PIPE_STAGE_PERF_EN
    input  logic        perf_clr,
    output logic [15:0] stall_cycles,
`endif
    pipe_stage_buf_if.slave bus
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;
    logic              inReady;
    logic              outValid;
    logic              pushEn;
    logic              popEn;
    logic [DATA_W-1:0] outData;
    logic [DATA_W-1:0] entryMem [DEPTH];

    // A full buffer still accepts when the head leaves in the same cycle;
    // this makes in_ready combinational in out_ready on purpose.
    assign inReady  = (count < CNT_W'(DEPTH)) | bus.out_ready;
    assign outValid = (count != '0);

    // A same-cycle push is lost on flush; a same-cycle pop still counts as
    // consumed by downstream, the pointer clear simply wins over it.
    assign pushEn = bus.in_valid & inReady & ~bus.flush;
    assign popEn  = outValid & bus.out_ready;

    pipe_buf_ptr #(
        .DEPTH (DEPTH)
    ) uPtr (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pushEn),
        .pop   (popEn),
        .clear (bus.flush),
        .wrPtr (wrPtr),
        .rdPtr (rdPtr),
        .count (count)
    );

    // Payload storage carries no reset; occupancy alone says what is live.
    always_ff @(posedge clk) begin
        if (pushEn) entryMem[wrPtr] <= bus.in_data;
    end

    // An empty stage presents an all-zero (NOP) bundle when ZERO_BUBBLE is set.
    always_comb begin
        outData = entryMem[rdPtr];
        if (ZERO_BUBBLE && !outValid) outData = '0;
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.out_data  = outData;
    assign bus.count     = count;

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stallCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (perf_clr) begin
            stallCnt <= '0;
        end else if (outValid && !bus.out_ready && (stallCnt != 16'hFFFF)) begin
            stallCnt <= stallCnt + 16'd1;
        end
    end

    assign stall_cycles = stallCnt;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed bench for pipe_stage_buf (DATA_W=120, DEPTH=2).
// Driver tasks push accepted bundles into exp_q; a monitor pops and compares
// whenever the DUT completes an output transfer.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int W = 120;
    localparam int D = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pipe_stage_buf_if #(.DATA_W(W), .DEPTH(D)) bus ();

`ifdef PIPE_STAGE_PERF_EN
    logic        perf_clr = 1'b0;
    logic [15:0] stall_cycles;
`endif

    pipe_stage_buf #(
        .DATA_W      (W),
        .DEPTH       (D),
        .ZERO_BUBBLE (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef PIPE_STAGE_PERF_EN
        .perf_clr     (perf_clr),
        .stall_cycles (stall_cycles),
`endif
        .bus          (bus)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every completed output transfer against exp_q and
    // requires an all-zero bundle whenever nothing is presented.
    initial begin
        logic [W-1:0] exp_val;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.out_valid === 1'b1) begin
                    if (bus.out_ready === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_out: got %0h expected nothing at %0t",
                                     bus.out_data, $time);
                        end else begin
                            exp_val = exp_q.pop_front();
                            chk("out_data", bus.out_data, exp_val);
                        end
                    end
                end else begin
                    chk("bubble_zero", bus.out_data, '0);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // One clock cycle: drive inputs (called just after a posedge), check the
    // expected in_ready / count / out_valid before the next edge, record an
    // expected push, then advance past the edge.
    task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy,
                         input logic fl, input logic exp_rdy, input int exp_cnt);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(negedge clk);
        chk("in_ready",  bus.in_ready,  exp_rdy);
        chk("count",     bus.count,     exp_cnt);
        chk("out_valid", bus.out_valid, exp_cnt != 0);
        if (iv && exp_rdy && !fl) exp_q.push_back(d);
        @(posedge clk);
        #1;
        if (fl) exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mcnt;
        int next_val;
        int cyc;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;

        // ---- reset state ----
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count",     bus.count,     0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_in_ready",  bus.in_ready,  1);
`ifdef PIPE_STAGE_PERF_EN
        chk("rst_stall", stall_cycles, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- single push, 1-cycle latency, then empty ----
        cycle(1'b1, W'(120'h1234), 1'b1, 1'b0, 1'b1, 0);
        cycle(1'b0, '0,            1'b1, 1'b0, 1'b1, 1);
        cycle(1'b0, '0,            1'b1, 1'b0, 1'b1, 0);

        // ---- fill, third push refused, drain in order ----
        cycle(1'b1, W'(5), 1'b0, 1'b0, 1'b1, 0);
        cycle(1'b1, W'(6), 1'b0, 1'b0, 1'b1, 1);
        cycle(1'b1, W'(7), 1'b0, 1'b0, 1'b0, 2);
        cycle(1'b0, '0,    1'b1, 1'b0, 1'b1, 2);
        cycle(1'b0, '0,    1'b1, 1'b0, 1'b1, 1);
        cycle(1'b0, '0,    1'b1, 1'b0, 1'b1, 0);

        // ---- full with simultaneous push C and pop A ----
        cycle(1'b1, W'(5), 1'b0, 1'b0, 1'b1, 0);
        cycle(1'b1, W'(6), 1'b0, 1'b0, 1'b1, 1);
        cycle(1'b1, W'(7), 1'b1, 1'b0, 1'b1, 2);
        cycle(1'b0, '0,    1'b1, 1'b0, 1'b1, 2);
        cycle(1'b0, '0,    1'b1, 1'b0, 1'b1, 1);
        cycle(1'b0, '0,    1'b1, 1'b0, 1'b1, 0);

        // ---- flush while full with push D=9 and pop A in the same cycle ----
        cycle(1'b1, W'(5), 1'b0, 1'b0, 1'b1, 0);
        cycle(1'b1, W'(6), 1'b0, 1'b0, 1'b1, 1);
        cycle(1'b1, W'(9), 1'b1, 1'b1, 1'b1, 2);
        cycle(1'b0, '0,    1'b1, 1'b0, 1'b1, 0);
        cycle(1'b0, '0,    1'b1, 1'b0, 1'b1, 0);

        // ---- flush while full with downstream stalled ----
        cycle(1'b1, W'(8),  1'b0, 1'b0, 1'b1, 0);
        cycle(1'b1, W'(10), 1'b0, 1'b0, 1'b1, 1);
        cycle(1'b1, W'(9),  1'b0, 1'b1, 1'b0, 2);
        cycle(1'b0, '0,     1'b1, 1'b0, 1'b1, 0);

        // ---- wrap-around: values 1..10, out_ready toggling ----
        mcnt     = 0;
        next_val = 1;
        cyc      = 0;
        while (next_val <= 10 && cyc < 100) begin
            logic ordy;
            logic acc;
            logic pp;
            ordy = (cyc % 2 == 0);
            acc  = (mcnt < D) || ordy;
            pp   = (mcnt != 0) && ordy;
            cycle(1'b1, W'(next_val), ordy, 1'b0, acc, mcnt);
            if (acc) next_val++;
            mcnt = mcnt + int'(acc) - int'(pp);
            cyc++;
        end
        cyc = 0;
        while (mcnt > 0 && cyc < 20) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, mcnt);
            mcnt--;
            cyc++;
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 0);

        // ---- asynchronous reset while holding two entries ----
        cycle(1'b1, W'(11), 1'b0, 1'b0, 1'b1, 0);
        cycle(1'b1, W'(12), 1'b0, 1'b0, 1'b1, 1);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count",     bus.count,     0);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_data",  bus.out_data,  0);
        chk("arst_in_ready",  bus.in_ready,  1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 0);

`ifdef PIPE_STAGE_PERF_EN
        // ---- stall counter saturation and clear ----
        perf_clr = 1'b1;
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 0);
        perf_clr = 1'b0;
        chk("stall_clr0", stall_cycles, 0);
        cycle(1'b1, W'(120'h77), 1'b0, 1'b0, 1'b1, 0);
        bus.in_valid = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        chk("stall_sat", stall_cycles, 16'hFFFF);
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        chk("stall_clr", stall_cycles, 0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 0);
`endif

        // ---- final report ----
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
